// File: rtl/m16_rd_arbiter.sv
// Shares one word-buffer read port among NCH frame formers. Strobes are synchronised and edge-detected; the channels are served round-robin.
// Latency: req rise to ISSUE takes 4 clk. word_vld follows ISSUE by MEM_LAT+1 clk. One read completes every MEM_LAT+2 clk.
// Backpressure: none. A re-request to a still-pending channel replaces the address and sets overrun. Optional: M16_PRIORITY_EN.
module m16_rd_arbiter #(
  parameter int NCH     = 5,
  parameter int AW      = 11,
  parameter int DW      = 12,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] addr,
  output logic              mem_rd_en,
  output logic [2:0]        mem_sel,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_data,
  output logic [NCH*DW-1:0] word_out,
  output logic [NCH-1:0]    word_vld,
  output logic [NCH-1:0]    overrun,
  input  logic              clr_ovr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPT} state_t;

  state_t          state, stateNxt;
  logic [NCH-1:0]  reqS1, reqS2, reqS3, reqEdge;
  logic [NCH-1:0]  pending, issueHit, cand;
  logic [AW-1:0]   capAddr [NCH];
  logic [DW-1:0]   wordQ [NCH];
  logic [NCH-1:0]  wordVldQ;
  logic [2:0]      ptr, ptrNxt, grant, pick;
  logic            pickVld;
  logic [2:0]      latCnt, latCntNxt;
  logic [AW-1:0]   memAddrQ;
  logic [3:0]      sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqS1 <= '0;
      reqS2 <= '0;
      reqS3 <= '0;
    end else begin
      reqS1 <= req;
      reqS2 <= reqS1;
      reqS3 <= reqS2;
    end
  end

  assign reqEdge = reqS2 & ~reqS3;

  always_comb begin
    issueHit = '0;
    if (state == ISSUE) issueHit[grant] = 1'b1;
  end

  // An edge landing on the issue cycle starts a fresh request rather than an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NCH; i++) capAddr[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (reqEdge[i]) begin
          pending[i] <= 1'b1;
          capAddr[i] <= addr[i*AW +: AW];
        end else if (issueHit[i]) begin
          pending[i] <= 1'b0;
        end
      end
      overrun <= (overrun & ~{NCH{clr_ovr}}) | (reqEdge & pending & ~issueHit);
    end
  end

  // The search loop runs downwards, so the candidate nearest ptr is assigned last and wins.
  always_comb begin
    pick    = '0;
    pickVld = 1'b0;
    sum     = '0;
    cand    = pending;
`ifdef M16_PRIORITY_EN
    cand[0] = 1'b0;
`endif
    for (int k = NCH-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(NCH)) sum = sum - 4'(NCH);
      if (cand[sum[2:0]]) begin
        pick    = sum[2:0];
        pickVld = 1'b1;
      end
    end
`ifdef M16_PRIORITY_EN
    if (pending[0]) begin
      pick    = '0;
      pickVld = 1'b1;
    end
`endif
  end

  always_comb begin
    stateNxt  = state;
    latCntNxt = latCnt;
    case (state)
      IDLE:  if (pickVld) stateNxt = ISSUE;
      ISSUE: begin
        latCntNxt = 3'(MEM_LAT-1);
        stateNxt  = (MEM_LAT == 1) ? CAPT : WAIT;
      end
      WAIT: begin
        latCntNxt = latCnt - 3'd1;
        if (latCnt == 3'd1) stateNxt = CAPT;
      end
      CAPT:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  assign ptrNxt = (grant == 3'(NCH-1)) ? 3'd0 : grant + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      latCnt   <= '0;
      grant    <= '0;
      ptr      <= '0;
      memAddrQ <= '0;
      wordVldQ <= '0;
      for (int i = 0; i < NCH; i++) wordQ[i] <= '0;
    end else begin
      state    <= stateNxt;
      latCnt   <= latCntNxt;
      wordVldQ <= '0;
      if (state == IDLE && pickVld) grant <= pick;
      if (state == ISSUE) memAddrQ <= capAddr[grant];
      if (state == CAPT) begin
        wordQ[grant]    <= mem_data;
        wordVldQ[grant] <= 1'b1;
`ifdef M16_PRIORITY_EN
        if (grant != 3'd0) ptr <= ptrNxt;
`else
        ptr <= ptrNxt;
`endif
      end
    end
  end

  assign mem_rd_en = (state == ISSUE);
  assign mem_sel   = grant;
  assign mem_addr  = (state == ISSUE) ? capAddr[grant] : memAddrQ;
  assign word_vld  = wordVldQ;

  for (genvar g = 0; g < NCH; g++) begin : gWord
    assign word_out[g*DW +: DW] = wordQ[g];
  end

endmodule
